io_out_port: RTL

- Output-side peripheral for final_processor; the receiving end of the processor's output interface.
- The processor drives a write strobe with a data word (normally top_of_stack) on an OUT instruction.
- This block buffers those words in a small FIFO and drains them to an external consumer over a valid/ready handshake.
- It decouples processor execution from a slow sink and reports drops on overflow.

---
 rtl/io_out_port.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/io_out_port.sv
// io_out_port: output-side peripheral for final_processor.
// Buffers words written by the processor's OUT instruction in a small FIFO and
// drains them to an external consumer over a valid/ready handshake. Writes that
// arrive while the FIFO is full (and nothing is popped) are dropped and latch a
// sticky overflow flag. The head word is presented first-word-fall-through from
// a register, so every output is glitch-free and free of combinational paths
// from the inputs.
// Optional feature: define IO_OUT_TAG_EN to add a 4-bit per-word sequence tag
// on out_tag, presented in lockstep with out_data.
module io_out_port #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              full,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [ADDR_W:0]   count,
    output logic              overflow
`ifdef IO_OUT_TAG_EN
    ,
    output logic [3:0]        out_tag
`endif
);

    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_full;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic              r_overflow;

    logic              w_pop;
    logic              w_push;
    logic              w_drop;
    logic [ADDR_W:0]   w_count_nxt;
    logic [ADDR_W-1:0] w_head_idx;
    logic              w_head_bypass;
    logic [DATA_W-1:0] w_out_data_nxt;

`ifdef IO_OUT_TAG_EN
    logic [3:0]        r_tag_mem [DEPTH];
    logic [3:0]        r_seq;
    logic [3:0]        r_out_tag;
    logic [3:0]        w_out_tag_nxt;
`endif

    // Handshake decode, next occupancy and the word that will sit at the head after this edge.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_pop          = r_out_valid && out_ready;
        w_push         = wr_en && (!r_full || w_pop);
        w_drop         = wr_en && !w_push;
        w_count_nxt    = r_count;
        w_head_idx     = r_rd_ptr;
        w_head_bypass  = 1'b0;
        w_out_data_nxt = r_out_data;

        if (w_push && !w_pop) begin
            w_count_nxt = r_count + CNT_ONE;
        end else if (w_pop && !w_push) begin
            w_count_nxt = r_count - CNT_ONE;
        end

        if (w_pop) begin
            w_head_idx = r_rd_ptr + PTR_ONE;
        end

        // The incoming word becomes the head when it lands exactly at the new read slot
        // (write into empty, or push+pop with one entry); it is not in r_mem yet.
        w_head_bypass = w_push && (w_head_idx == r_wr_ptr);

        if (w_count_nxt != '0) begin
            w_out_data_nxt = w_head_bypass ? wr_data : r_mem[w_head_idx];
        end
    end

    // Pointers, occupancy, flags and the registered head word.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_full      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            r_count     <= w_count_nxt;
            r_full      <= (w_count_nxt == CNT_FULL);
            r_out_valid <= (w_count_nxt != '0);
            r_out_data  <= w_out_data_nxt;
        end
    end

    // Storage write on every accepted push.
    // NOTE: storage has no reset; its contents are only read behind valid pointers.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

`ifdef IO_OUT_TAG_EN
    // Tag that follows the head word, chosen the same way as the head data.
    always_comb begin
        w_out_tag_nxt = r_out_tag;
        if (w_count_nxt != '0) begin
            w_out_tag_nxt = w_head_bypass ? r_seq : r_tag_mem[w_head_idx];
        end
    end

    // Sequence counter (accepted writes only) and registered head tag.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_seq     <= '0;
            r_out_tag <= '0;
        end else begin
            if (w_push) begin
                r_seq <= r_seq + 4'd1;
            end
            r_out_tag <= w_out_tag_nxt;
        end
    end

    // Tag storage alongside each data word.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_tag_mem[r_wr_ptr] <= r_seq;
        end
    end

    assign out_tag = r_out_tag;
`endif

    assign full      = r_full;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign count     = r_count;
    assign overflow  = r_overflow;

endmodule
